// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction pipeline stage units.
package pipe_pkg;

  localparam int INSTR_W_DEF = 32;
  localparam int EPOCH_W_DEF = 1;

  // Architectural NOP that a squashed or empty stage presents downstream.
  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 32'hE320F000;

  typedef logic [EPOCH_W_DEF-1:0] epoch_t;

  // One held stage entry at the default widths.
  typedef struct packed {
    logic                   valid;
    logic [INSTR_W_DEF-1:0] instr;
    epoch_t                 epoch;
  } stage_entry_t;

endpackage

// File: rtl/instr_pipe_stage_if.sv
// Handshake bus around one pipeline stage: upstream in_* side and downstream out_* side.
interface instr_pipe_stage_if #(
  parameter int INSTR_W = 32,
  parameter int EPOCH_W = 1
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [EPOCH_W-1:0] in_epoch;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [EPOCH_W-1:0] out_epoch;
  logic               out_squashed;

  // Environment side: feeds instructions in and consumes the stage output.
  modport master (
    output in_valid, in_instr, in_epoch, out_ready,
    input  in_ready, out_valid, out_instr, out_epoch, out_squashed
  );

  // Stage side.
  modport slave (
    input  in_valid, in_instr, in_epoch, out_ready,
    output in_ready, out_valid, out_instr, out_epoch, out_squashed
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. in_ready comes only from flops,
// so there is no combinational path from out_ready back to in_ready.
module pipe_skid_buf #(
  parameter int           W        = 33,
  parameter logic [W-1:0] CLR_DATA = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic [W-1:0] main_data;
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         flush_q;
  logic         accept;
  logic         fire;

  assign in_ready  = ~skid_valid & ~flush_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign accept    = in_valid & in_ready;
  assign fire      = main_valid & out_ready;

  // Main/skid entry update; flush discards everything, including a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= CLR_DATA;
      skid_valid <= 1'b0;
      skid_data  <= CLR_DATA;
      flush_q    <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_data  <= CLR_DATA;
      skid_valid <= 1'b0;
      skid_data  <= CLR_DATA;
      flush_q    <= 1'b1;
    end else begin
      flush_q <= 1'b0;
      if (!main_valid || fire) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end else if (accept) begin
          main_valid <= 1'b1;
          main_data  <= in_data;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        // Main is stalled; in_ready guarantees skid is free here.
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end
  end

endmodule

// File: rtl/instr_pipe_stage.sv
// Instruction pipeline stage: skid-buffered handshake, epoch squash to NOP,
// synchronous flush and a saturating count of delivered squashed entries.
module instr_pipe_stage #(
  parameter int                 INSTR_W   = 32,
  parameter int                 EPOCH_W   = 1,
  parameter int                 CNT_W     = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(pipe_pkg::NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_pipe_stage_if.slave  bus,
  input  logic [EPOCH_W-1:0] cur_epoch,
  input  logic               flush,
  output logic [CNT_W-1:0]   squash_count
);

  localparam int PW = INSTR_W + EPOCH_W;

  logic               main_valid;
  logic [PW-1:0]      main_data;
  logic [INSTR_W-1:0] main_instr;
  logic [EPOCH_W-1:0] main_epoch;
  logic               squashed;
  logic               fire;

  pipe_skid_buf #(
    .W        (PW),
    .CLR_DATA ({{EPOCH_W{1'b0}}, NOP_INSTR})
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   ({bus.in_epoch, bus.in_instr}),
    .out_valid (main_valid),
    .out_ready (bus.out_ready),
    .out_data  (main_data)
  );

  assign main_instr = main_data[INSTR_W-1:0];
  assign main_epoch = main_data[PW-1:INSTR_W];

  // Live cur_epoch: a stalled entry can become squashed (or un-squashed) while waiting.
  assign squashed = main_valid & (main_epoch != cur_epoch);
  assign fire     = main_valid & bus.out_ready;

  assign bus.out_valid    = main_valid;
  assign bus.out_squashed = squashed;
  assign bus.out_epoch    = main_epoch;
  assign bus.out_instr    = (!main_valid || squashed) ? NOP_INSTR : main_instr;

  // Count squashed bubbles actually handed downstream; a flush cancels the fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      squash_count <= '0;
    end else if (fire && squashed && !flush && (squash_count != {CNT_W{1'b1}})) begin
      squash_count <= squash_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_pipe_stage.sv
// Directed self-checking bench for instr_pipe_stage.
module tb_instr_pipe_stage;

  localparam logic [31:0] NOP = 32'hE320F000;

  logic        clk;
  logic        rst_n;
  logic        cur_epoch;
  logic        flush;
  logic [15:0] squash_count;
  logic        cur_epoch2;
  logic        flush2;
  logic [1:0]  squash_count2;

  int total;
  int bad;

  instr_pipe_stage_if #(.INSTR_W(32), .EPOCH_W(1)) bus ();
  instr_pipe_stage_if #(.INSTR_W(32), .EPOCH_W(1)) bus2 ();

  instr_pipe_stage #(.INSTR_W(32), .EPOCH_W(1), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .cur_epoch    (cur_epoch),
    .flush        (flush),
    .squash_count (squash_count)
  );

  instr_pipe_stage #(.INSTR_W(32), .EPOCH_W(1), .CNT_W(2)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus2.slave),
    .cur_epoch    (cur_epoch2),
    .flush        (flush2),
    .squash_count (squash_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_instr !== NOP) begin bad++; $display("FAIL reset_out_instr got=%h exp=%h", bus.out_instr, NOP); end
    total++; if (bus.out_epoch !== 1'b0) begin bad++; $display("FAIL reset_out_epoch got=%b exp=0", bus.out_epoch); end
    total++; if (bus.out_squashed !== 1'b0) begin bad++; $display("FAIL reset_out_squashed got=%b exp=0", bus.out_squashed); end
    total++; if (squash_count !== 16'd0) begin bad++; $display("FAIL reset_squash_count got=%0d exp=0", squash_count); end
  endtask

  task automatic test_single();
    bus.in_valid = 1'b1; bus.in_instr = 32'hE2811001; bus.in_epoch = 1'b0;
    cur_epoch = 1'b0; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
    total++; if (bus.out_instr !== 32'hE2811001) begin bad++; $display("FAIL single_instr got=%h exp=e2811001", bus.out_instr); end
    total++; if (bus.out_squashed !== 1'b0) begin bad++; $display("FAIL single_squashed got=%b exp=0", bus.out_squashed); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [3];
    seq[0] = 32'h11111111; seq[1] = 32'h22222222; seq[2] = 32'h33333333;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_instr = seq[i]; bus.in_epoch = 1'b0;
      step();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== seq[i] || bus.in_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_%0d got v=%b i=%h r=%b exp v=1 i=%h r=1", i, bus.out_valid, bus.out_instr, bus.in_ready, seq[i]);
      end
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    logic [31:0] items [4];
    int idx, nout;
    logic acc, fir, chk;
    items[0] = 32'hA0000001; items[1] = 32'hB0000002; items[2] = 32'hC0000003; items[3] = 32'hD0000004;
    idx = 0; nout = 0; chk = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (idx == 4 && nout == 4) break;
      bus.out_ready = (cyc >= 4);
      bus.in_valid  = (idx < 4);
      bus.in_instr  = (idx < 4) ? items[idx] : 32'h0;
      bus.in_epoch  = 1'b0;
      #0;
      acc = bus.in_valid & bus.in_ready;
      fir = bus.out_valid & bus.out_ready;
      if (fir) begin
        total++;
        if (nout >= 4 || bus.out_instr !== items[nout]) begin
          bad++; $display("FAIL stall_order_%0d got=%h exp=%h", nout, bus.out_instr, (nout < 4) ? items[nout] : 32'h0);
        end
        nout++;
      end
      step();
      if (acc) idx++;
      if (idx == 2 && !chk) begin
        chk = 1'b1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready_full got=%b exp=0", bus.in_ready); end
      end
    end
    bus.in_valid = 1'b0;
    total++; if (nout != 4 || idx != 4) begin bad++; $display("FAIL stall_count got out=%0d in=%0d exp 4/4", nout, idx); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_no_dup got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_squash();
    bus.out_ready = 1'b0; cur_epoch = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'hE0811002; bus.in_epoch = 1'b0;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_squashed !== 1'b0 || bus.out_instr !== 32'hE0811002) begin bad++; $display("FAIL squash_pre got s=%b i=%h exp s=0 i=e0811002", bus.out_squashed, bus.out_instr); end
    cur_epoch = 1'b1;
    #1;
    total++; if (bus.out_squashed !== 1'b1 || bus.out_instr !== NOP || bus.out_valid !== 1'b1) begin bad++; $display("FAIL squash_live got s=%b i=%h v=%b exp s=1 i=%h v=1", bus.out_squashed, bus.out_instr, bus.out_valid, NOP); end
    total++; if (bus.out_epoch !== 1'b0) begin bad++; $display("FAIL squash_epoch got=%b exp=0", bus.out_epoch); end
    bus.out_ready = 1'b1;
    step();
    total++; if (squash_count !== 16'd1) begin bad++; $display("FAIL squash_count got=%0d exp=1", squash_count); end
    // Matching non-zero epoch passes through untouched.
    bus.in_valid = 1'b1; bus.in_instr = 32'hE1A00000; bus.in_epoch = 1'b1;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_squashed !== 1'b0 || bus.out_epoch !== 1'b1 || bus.out_instr !== 32'hE1A00000) begin bad++; $display("FAIL squash_match got s=%b e=%b i=%h exp s=0 e=1 i=e1a00000", bus.out_squashed, bus.out_epoch, bus.out_instr); end
    step();
    cur_epoch = 1'b0;
    total++; if (squash_count !== 16'd1) begin bad++; $display("FAIL squash_count_hold got=%0d exp=1", squash_count); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h01020304; bus.in_epoch = 1'b0;
    step();
    bus.in_instr = 32'h05060708;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL flush_full got r=%b v=%b exp r=0 v=1", bus.in_ready, bus.out_valid); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.out_instr !== NOP || bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_next got v=%b i=%h r=%b exp v=0 i=%h r=0", bus.out_valid, bus.out_instr, bus.in_ready, NOP); end
    step();
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_after got r=%b v=%b exp r=1 v=0", bus.in_ready, bus.out_valid); end
    total++; if (squash_count !== 16'd1) begin bad++; $display("FAIL flush_count got=%0d exp=1", squash_count); end
    // Input accepted in a flush cycle is dropped.
    bus.in_valid = 1'b1; bus.in_instr = 32'h0BADF00D; flush = 1'b1;
    step();
    bus.in_valid = 1'b0; flush = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop got v=%b exp=0", bus.out_valid); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop2 got v=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_saturate();
    int fires;
    int expc;
    fires = 0;
    cur_epoch2 = 1'b1; bus2.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      logic fir;
      if (fires == 5) break;
      bus2.in_valid = (cyc < 5); bus2.in_instr = 32'h100 + cyc; bus2.in_epoch = 1'b0;
      #0;
      fir = bus2.out_valid & bus2.out_ready;
      if (fir) begin
        total++; if (bus2.out_instr !== NOP) begin bad++; $display("FAIL sat_bubble_%0d got=%h exp=%h", fires, bus2.out_instr, NOP); end
      end
      step();
      if (fir) begin
        fires++;
        expc = (fires > 3) ? 3 : fires;
        total++; if (squash_count2 !== 2'(expc)) begin bad++; $display("FAIL sat_count_%0d got=%0d exp=%0d", fires, squash_count2, expc); end
      end
    end
    bus2.in_valid = 1'b0;
    total++; if (fires != 5) begin bad++; $display("FAIL sat_fires got=%0d exp=5", fires); end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'hCAFE0001; bus.in_epoch = 1'b0;
    step();
    bus.in_instr = 32'hCAFE0002;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL arst_full got r=%b v=%b exp r=0 v=1", bus.in_ready, bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL arst_now got v=%b r=%b exp v=0 r=1", bus.out_valid, bus.in_ready); end
    total++; if (squash_count !== 16'd0 || bus.out_instr !== NOP) begin bad++; $display("FAIL arst_state got c=%0d i=%h exp c=0 i=%h", squash_count, bus.out_instr, NOP); end
    #2 rst_n = 1'b1;
    step();
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; flush = 1'b0; cur_epoch = 1'b0;
    flush2 = 1'b0; cur_epoch2 = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_epoch = '0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_instr = '0; bus2.in_epoch = '0; bus2.out_ready = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    step();
    test_single();
    test_back_to_back();
    test_stall();
    test_squash();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
